// File: rtl/onehot_encoder_drain.sv
// onehot_encoder_drain: sequential N-to-log2(N) encoder.
// Captures a request vector on a valid/ready handshake and drains it as
// binary indices, lowest set bit first, one per output handshake.
//
// Ports:
//   clk, rst          rising-edge clock, synchronous active-high reset
//   in_valid/in_ready input handshake, in_vec = request vector
//   out_valid/ready   output handshake
//   out_idx           index of lowest pending request
//   out_last          out_idx is the final pending request
//   zero_err          one-cycle pulse after an all-zero vector is accepted
module onehot_encoder_drain #(
    parameter int WIDTH = 4,
    localparam int IDX_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_vec,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [IDX_W-1:0] out_idx,
    output logic             out_last,
    output logic             zero_err
);

    generate
        if (WIDTH < 2 || (WIDTH & (WIDTH - 1)) != 0) begin : g_bad_width
            $error("onehot_encoder_drain: WIDTH must be a power of 2 >= 2");
        end
    endgenerate

    typedef enum logic {
        IDLE  = 1'b0,
        DRAIN = 1'b1
    } state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] pending_q, pending_d;
    logic             out_valid_q, out_valid_d;
    logic [IDX_W-1:0] out_idx_q, out_idx_d;
    logic             out_last_q, out_last_d;
    logic             zero_err_q, zero_err_d;
    logic [WIDTH-1:0] pending_next;

    // Scanning from the top down lets the lowest set bit win.
    function automatic logic [IDX_W-1:0] low_idx(input logic [WIDTH-1:0] v);
        low_idx = '0;
        for (int k = WIDTH - 1; k >= 0; k--) begin
            if (v[k]) low_idx = IDX_W'(k);
        end
    endfunction

    function automatic logic single_bit(input logic [WIDTH-1:0] v);
        single_bit = (v != '0) && ((v & (v - WIDTH'(1))) == '0);
    endfunction

    assign in_ready = (state_q == IDLE) && !rst;

    // Clearing the lowest set bit: v & (v - 1).
    assign pending_next = pending_q & (pending_q - WIDTH'(1));

    always_comb begin
        state_d     = state_q;
        pending_d   = pending_q;
        out_valid_d = out_valid_q;
        out_idx_d   = out_idx_q;
        out_last_d  = out_last_q;
        zero_err_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    if (in_vec != '0) begin
                        state_d     = DRAIN;
                        pending_d   = in_vec;
                        out_valid_d = 1'b1;
                        out_idx_d   = low_idx(in_vec);
                        out_last_d  = single_bit(in_vec);
                    end else begin
                        zero_err_d = 1'b1;
                    end
                end
            end
            DRAIN: begin
                // out_ready is only looked at here, where out_valid is 1.
                if (out_ready) begin
                    pending_d = pending_next;
                    if (out_last_q) begin
                        state_d     = IDLE;
                        out_valid_d = 1'b0;
                        out_idx_d   = '0;
                        out_last_d  = 1'b0;
                    end else begin
                        out_idx_d  = low_idx(pending_next);
                        out_last_d = single_bit(pending_next);
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            pending_q   <= '0;
            out_valid_q <= 1'b0;
            out_idx_q   <= '0;
            out_last_q  <= 1'b0;
            zero_err_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            pending_q   <= pending_d;
            out_valid_q <= out_valid_d;
            out_idx_q   <= out_idx_d;
            out_last_q  <= out_last_d;
            zero_err_q  <= zero_err_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_idx   = out_idx_q;
    assign out_last  = out_last_q;
    assign zero_err  = zero_err_q;

endmodule

// File: tb/tb_onehot_encoder_drain.sv
// Testbench for onehot_encoder_drain (WIDTH=8): directed scenarios plus
// randomized traffic checked against a queue-based reference model.
module tb_onehot_encoder_drain;

    localparam int W  = 8;
    localparam int IW = $clog2(W);

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  in_vec;
    logic          out_valid;
    logic          out_ready;
    logic [IW-1:0] out_idx;
    logic          out_last;
    logic          zero_err;

    int n_chk  = 0;
    int n_fail = 0;

    // Reference model: indices still to be emitted, and the error pulse.
    int q[$];
    bit m_zerr;

    onehot_encoder_drain #(.WIDTH(W)) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_vec   (in_vec),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_idx  (out_idx),
        .out_last (out_last),
        .zero_err (zero_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int got, input int exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_outputs();
        int e_valid;
        int e_idx;
        int e_last;
        e_valid = (q.size() > 0) ? 1 : 0;
        e_idx   = e_valid ? q[0] : 0;
        e_last  = (q.size() == 1) ? 1 : 0;
        chk("out_valid", int'(out_valid), e_valid);
        chk("out_idx",   int'(out_idx),   e_idx);
        chk("out_last",  int'(out_last),  e_last);
        chk("zero_err",  int'(zero_err),  int'(m_zerr));
        chk("in_ready",  int'(in_ready),  (q.size() == 0 && !rst) ? 1 : 0);
    endtask

    // One clock cycle: check at negedge, drive, then advance model at posedge.
    task automatic cyc(input logic r, input logic iv,
                       input logic [W-1:0] v, input logic ordy);
        @(negedge clk);
        check_outputs();
        rst       = r;
        in_valid  = iv;
        in_vec    = v;
        out_ready = ordy;
        @(posedge clk);
        if (r) begin
            q.delete();
            m_zerr = 0;
        end else if (q.size() == 0) begin
            m_zerr = 0;
            if (iv) begin
                if (v == '0) m_zerr = 1;
                else for (int k = 0; k < W; k++) if (v[k]) q.push_back(k);
            end
        end else begin
            m_zerr = 0;
            if (ordy) void'(q.pop_front());
        end
    endtask

    task automatic idle_n(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, '0, 1'b1);
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_vec    = '0;
        out_ready = 1'b0;
        m_zerr    = 0;
        repeat (2) @(posedge clk);
        // Reset held one more cycle, with in_valid: reset wins.
        cyc(1'b1, 1'b1, 8'h0F, 1'b1);
        // Single-bit vectors back to back.
        cyc(1'b0, 1'b1, 8'h01, 1'b1);
        cyc(1'b0, 1'b1, 8'h02, 1'b1);
        cyc(1'b0, 1'b1, 8'h02, 1'b1);
        idle_n(2);
        // Multi-hot drain 0,1,3.
        cyc(1'b0, 1'b1, 8'h0B, 1'b1);
        idle_n(4);
        // Stall 3 cycles while in_vec changes, then drain 1,2.
        cyc(1'b0, 1'b1, 8'h06, 1'b0);
        for (int i = 0; i < 3; i++) cyc(1'b0, 1'b1, 8'hFF, 1'b0);
        idle_n(3);
        // All-zero vector.
        cyc(1'b0, 1'b1, 8'h00, 1'b1);
        idle_n(2);
        // Reset in the middle of draining 8'hFF, then MSB only.
        cyc(1'b0, 1'b1, 8'hFF, 1'b1);
        idle_n(3);
        cyc(1'b1, 1'b0, '0, 1'b1);
        idle_n(1);
        cyc(1'b0, 1'b1, 8'h80, 1'b1);
        idle_n(2);
        // Randomized traffic.
        for (int i = 0; i < 600; i++) begin
            logic          r;
            logic          iv;
            logic [W-1:0]  v;
            logic          o;
            r  = ($urandom_range(0, 49) == 0);
            iv = ($urandom_range(0, 1) == 1);
            v  = ($urandom_range(0, 4) == 0) ? '0 : W'($urandom);
            o  = ($urandom_range(0, 9) < 7);
            cyc(r, iv, v, o);
        end
        idle_n(10);
        @(negedge clk);
        check_outputs();
        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/onehot_encoder_drain.md
Name: onehot_encoder_drain

Overview:
- Sequential N-to-log2(N) encoder: the inverse direction of the team's 1-to-2 / N-way decoders.
- Accepts a request vector through a valid/ready handshake.
- Emits the index of each set bit, lowest first, one per output handshake, until the captured vector is exhausted.
- Sits between decoded select/request lines and any consumer that needs binary indices. A one-hot input yields exactly one index; a multi-hot input is drained serially.

Parameters:
- WIDTH, 4: number of input request lines. Must be a power of 2 and at least 2. Elaboration fails otherwise.
- IDX_W, $clog2(WIDTH): output index width. Derived; must not be overridden.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous active-high reset
- in_valid  input  1  in_vec is presented
- in_ready  output  1  block can capture a new vector
- in_vec  input  WIDTH  request vector; bit k = request k
- out_valid  output  1  out_idx/out_last valid
- out_ready  input  1  consumer accepts current index
- out_idx  output  IDX_W  binary index of lowest pending bit
- out_last  output  1  current index is the final pending bit
- zero_err  output  1  one-cycle pulse: all-zero vector was accepted

Behaviour:
- One clock; reset is synchronous and active-high (clk, rst). All state updates on the rising clk edge.
- Reset values:
  - state=IDLE, pending=0, out_valid=0, out_idx=0, out_last=0, zero_err=0.
  - in_ready=0 while rst=1; in_ready=1 on the first cycle after rst deasserts.
- Internal state: state {IDLE, DRAIN}; pending register, WIDTH bits.
- in_ready = (state==IDLE) && !rst, combinational. No input capture in DRAIN and no bypass.
- IDLE:
  - in_valid=1 with in_vec!=0: pending<=in_vec, state<=DRAIN.
  - in_valid=1 with in_vec==0: vector accepted and dropped. zero_err=1 for the next cycle only; state stays IDLE.
  - in_valid=0: hold.
- DRAIN, outputs registered from pending:
  - out_valid=1.
  - out_idx = position of the lowest set bit of pending.
  - out_last = 1 iff pending has exactly one bit set.
- DRAIN, on out_valid && out_ready:
  - Clear the lowest set bit of pending.
  - If out_last=1: state<=IDLE, out_valid<=0, out_idx<=0, out_last<=0.
  - Otherwise: the next index is presented on the following cycle.
- DRAIN, with out_ready=0: out_idx, out_last and out_valid hold stable, with no glitch and no change.
- Latency:
  - Input accepted at edge N → out_valid=1 after edge N.
  - With out_ready held at 1, one index per cycle. A vector with P set bits drains in P cycles.
  - in_ready returns 1 the cycle after the last handshake. Minimum input-to-input spacing is P+1 cycles.
- Encoding is exact unsigned binary: bit k → out_idx=k.
  - WIDTH=2: in_vec 2'b01 → idx 0; 2'b10 → idx 1 (inverse of decoder1to2).
  - MSB bit WIDTH-1 → idx WIDTH-1, all ones.
- in_vec is ignored whenever in_ready=0. Changing in_vec during DRAIN has no effect.
- Reset mid-DRAIN: pending is discarded. The next cycle shows out_valid=0 with no further indices emitted.
- rst and in_valid asserted together: rst wins and nothing is captured.
- X/Z on out_ready while out_valid=0 must not affect state.

Test Plan:
- WIDTH=2, rst 2 cycles, then in_vec=01 with valid, then 10, out_ready=1 → idx 0 last=1, then idx 1 last=1. in_ready=0 exactly one cycle per vector.
- WIDTH=4, in_vec=4'b1011, out_ready=1 → idx 0, 1, 3 on three consecutive cycles. out_last=0, 0, 1. in_ready=1 on the 4th cycle.
- WIDTH=4, in_vec=4'b0110, out_ready low 3 cycles then high → idx=1 held stable 3 cycles, then idx 1, 2 delivered. Changing in_vec to 1111 mid-drain has no effect.
- in_vec=0 with valid → zero_err=1 for exactly one cycle, out_valid stays 0, in_ready stays 1.
- WIDTH=8, in_vec=8'hFF with rst asserted after 3 handshakes → idx 0, 1, 2 seen, then out_valid=0, pending cleared. Next vector 8'h80 → idx 7 last=1.
- WIDTH=8, in_vec=8'h80 → single output idx=3'b111, out_last=1.
